// File: rtl/mux_scan_sequencer.sv
// Clocked scan driver/checker for the lab 4:1 mux: drives a latched word on W,
// walks S through every input, samples y after a settle dwell and flags q != W.
module mux_scan_sequencer #(
  parameter int SEL_W = 2,
  parameter int DWELL = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [(1<<SEL_W)-1:0]   data_in,
  output logic [(1<<SEL_W)-1:0]   W,
  output logic [SEL_W-1:0]        S,
  input  logic                    y,
  output logic [(1<<SEL_W)-1:0]   q,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int N_IN = 1 << SEL_W;
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_IN-1:0]  r_w;
  logic [SEL_W-1:0] r_s;
  logic [N_IN-1:0]  r_q;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [N_IN-1:0]  w_qNext;

  // Word as it will look after the current sample lands; err compares this,
  // not r_q, so the final bit is included in the check.
  always_comb begin
    w_qNext      = r_q;
    w_qNext[r_s] = y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_w     <= '0;
      r_s     <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_w     <= data_in;
            r_s     <= '0;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_q <= w_qNext;
          if (r_s == SEL_LAST) begin
            r_err   <= (w_qNext != r_w);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_s     <= r_s + 1'b1;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign W    = r_w;
  assign S    = r_s;
  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 4:1 mux in the loop
// and a scoreboard of expected q/err popped on every done pulse.
module tb_mux_scan_sequencer;

  localparam int SEL_W    = 2;
  localparam int DWELL    = 2;
  localparam int N_IN     = 1 << SEL_W;
  localparam int SCAN_LAT = N_IN * (DWELL + 1);

  typedef struct packed {
    logic [N_IN-1:0] q;
    logic            err;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N_IN-1:0]  data_in;
  logic [N_IN-1:0]  W;
  logic [SEL_W-1:0] S;
  logic             y;
  logic [N_IN-1:0]  q;
  logic             busy;
  logic             done;
  logic             err;
  logic             stuckLow;

  exp_t             sb[$];
  int               doneCyc[$];
  int               nTests = 0;
  int               nFail = 0;
  int               doneCount = 0;
  int               cyc = 0;
  int               startCyc = 0;
  logic [N_IN-1:0]  expW = '0;
  logic [SEL_W-1:0] prevS = '0;
  logic             prevBusy = 1'b0;

  mux_scan_sequencer #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .W(W), .S(S), .y(y), .q(q), .busy(busy), .done(done), .err(err)
  );

  // Stand-in for the lab mux, with an optional stuck-at-0 output fault.
  assign y = stuckLow ? 1'b0 : W[S];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N_IN-1:0] d, input logic stuck);
    exp_t e;
    e.q   = stuck ? '0 : d;
    e.err = (e.q != d);
    return e;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      doneCount <= doneCount + 1;
      doneCyc.push_back(cyc);
      checkOutput("doneBusyExcl", {31'd0, busy}, 32'd0);
      checkOutput("doneSelLast", {30'd0, S}, N_IN - 1);
      checkOutput("wStable", {28'd0, W}, {28'd0, expW});
      if (sb.size() == 0) begin
        checkOutput("sbUnderflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        checkOutput("qWord", {28'd0, q}, {28'd0, e.q});
        checkOutput("errFlag", {31'd0, err}, {31'd0, e.err});
      end
    end
    if (busy && prevBusy && (S != prevS))
      checkOutput("selAscend", {30'd0, S}, {30'd0, prevS + 2'd1});
    prevS    <= S;
    prevBusy <= busy;
  end

  task automatic applyStimulus(input logic [N_IN-1:0] d);
    @(posedge clk); #1;
    data_in  = d;
    start    = 1'b1;
    expW     = d;
    startCyc = cyc;
    sb.push_back(model(d, stuckLow));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        c = cyc;
        return;
      end
    end
    checkOutput("doneTimeout", {31'd0, done}, 32'd1);
  endtask

  // Full scan of 4'b1010 with select timing checked cycle by cycle.
  task automatic scanTimingTest();
    applyStimulus(4'b1010);
    for (int i = 0; i < SCAN_LAT; i++) begin
      checkOutput("selDwell", {30'd0, S}, i / (DWELL + 1));
      @(posedge clk); #1;
    end
    checkOutput("doneAtLatency", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
    checkOutput("idleNotBusy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    int dc;
    int nd;
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    stuckLow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState", {18'd0, W, S, q, busy, done, err}, 32'd0);
    reset = 1'b0;

    scanTimingTest();

    for (int d = 0; d < 16; d++) begin
      dc = doneCount;
      applyStimulus(4'(d));
      waitDone(c);
      @(posedge clk); #1;
      checkOutput("onePerScan", doneCount - dc, 1);
    end

    stuckLow = 1'b1;
    applyStimulus(4'b0110);
    waitDone(c);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("errHold", {31'd0, err}, 32'd1);
    checkOutput("qStuck", {28'd0, q}, 32'd0);
    stuckLow = 1'b0;
    applyStimulus(4'b1010);
    checkOutput("errClearOnStart", {31'd0, err}, 32'd0);
    waitDone(c);

    applyStimulus(4'b1111);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("resetAbort", {18'd0, W, S, q, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    dc = doneCount;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("noDoneAfterAbort", doneCount - dc, 0);
    scanTimingTest();

    dc = doneCount;
    applyStimulus(4'b0101);
    repeat (3) @(posedge clk);
    #1;
    data_in = 4'b1111;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = 4'b0000;
    waitDone(c);
    checkOutput("midStartLatency", c - startCyc, SCAN_LAT + 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midStartIgnored", doneCount - dc, 1);

    dc = doneCount;
    nd = doneCyc.size();
    @(posedge clk); #1;
    data_in = 4'b0011;
    expW    = 4'b0011;
    start   = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(4'b0011, 1'b0));
    repeat (30) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("backToBackCount", doneCount - dc, 3);
    if (doneCyc.size() >= nd + 2)
      checkOutput("backToBackPeriod", doneCyc[nd+1] - doneCyc[nd], SCAN_LAT + 2);
    else
      checkOutput("backToBackPeriod", doneCyc.size(), nd + 2);
    checkOutput("sbDrained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
